// File: rtl/player_input_pkg.sv
// Shared types and constants for the player button input path.
package player_input_pkg;

  localparam int unsigned NUM_PLAYERS = 6;
  localparam int unsigned PLAYER_ID_W = 3;
  localparam int unsigned VALUE_W     = 3;

  typedef struct packed {
    logic [PLAYER_ID_W-1:0] id;
    logic [VALUE_W-1:0]     val;
    logic [NUM_PLAYERS-1:0] mask;
    logic                   multi;
  } press_event_t;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic more_than_one(input logic [NUM_PLAYERS-1:0] m);
    return (m & (m - NUM_PLAYERS'(1))) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, counting debouncer and registered press (0->1) pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      // The final mismatching cycle flips the level instead of bumping the count.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/player_input_sync.sv
// Debounces six player buttons, encodes same-cycle presses into one event and queues
// events in a show-ahead FIFO for the downstream game stage.
module player_input_sync
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] player_clk,
  input  logic [2:0] player1,
  input  logic [2:0] player2,
  input  logic [2:0] player3,
  input  logic [2:0] player4,
  input  logic [2:0] player5,
  input  logic [2:0] player6,
  input  logic       press_ready,
  output logic       press_valid,
  output logic [2:0] press_id,
  output logic [2:0] press_val,
  output logic [5:0] press_mask,
  output logic       multi_press,
  output logic       overflow,
  output logic [2:0] fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [NUM_PLAYERS-1:0][VALUE_W-1:0] raw_val, val_meta_q, val_sync_q;
  logic [NUM_PLAYERS-1:0]              press_vec;

  assign raw_val = {player6, player5, player4, player3, player2, player1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_meta_q <= '0;
      val_sync_q <= '0;
    end else begin
      val_meta_q <= raw_val;
      val_sync_q <= val_meta_q;
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_i  (clk),
      .rst_i  (reset),
      .btn_i  (player_clk[i]),
      .press_o(press_vec[i])
    );
  end

  // Priority encoder: the descending scan leaves the lowest-numbered player in place.
  press_event_t push_evt;
  logic         push;

  always_comb begin
    push_evt       = '0;
    push_evt.mask  = press_vec;
    push_evt.multi = more_than_one(press_vec);
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (press_vec[i]) begin
        push_evt.id  = PLAYER_ID_W'(i + 1);
        push_evt.val = val_sync_q[i];
      end
    end
  end

  assign push = |press_vec;

  press_event_t    mem_q [FIFO_DEPTH];
  press_event_t    head;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;
  logic            full, pop, wr_en;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = press_valid & press_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (pop)   rptr_q <= rptr_q + PtrW'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_evt;
  end

  assign head        = mem_q[rptr_q];
  assign press_valid = (count_q != '0);
  assign press_id    = press_valid ? head.id    : '0;
  assign press_val   = press_valid ? head.val   : '0;
  assign press_mask  = press_valid ? head.mask  : '0;
  assign multi_press = press_valid ? head.multi : 1'b0;
  assign overflow    = overflow_q;
  assign fifo_count  = 3'(count_q);

endmodule

// File: tb/tb_player_input_sync.sv
// Directed bench for player_input_sync: timed vector table plus overflow and reset sequences.
module tb_player_input_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] player_clk = '0;
  logic [2:0] player1 = '0, player2 = '0, player3 = '0;
  logic [2:0] player4 = '0, player5 = '0, player6 = '0;
  logic       press_ready = 1'b0;
  logic       press_valid, multi_press, overflow;
  logic [2:0] press_id, press_val, fifo_count;
  logic [5:0] press_mask;

  int checks = 0;
  int errors = 0;

  player_input_sync #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .player_clk (player_clk),
    .player1    (player1),
    .player2    (player2),
    .player3    (player3),
    .player4    (player4),
    .player5    (player5),
    .player6    (player6),
    .press_ready(press_ready),
    .press_valid(press_valid),
    .press_id   (press_id),
    .press_val  (press_val),
    .press_mask (press_mask),
    .multi_press(multi_press),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Inputs applied at a falling edge, then cyc falling edges later the outputs are compared.
  typedef struct {
    logic [5:0] btn;
    logic [2:0] p1;
    logic [2:0] p2;
    logic       rdy;
    int         cyc;
    logic       valid;
    logic [2:0] id;
    logic [2:0] val;
    logic [5:0] mask;
    logic       multi;
    logic [2:0] cnt;
  } vec_t;

  localparam int NumVecs = 16;
  vec_t vecs[NumVecs];

  function automatic vec_t mk(logic [5:0] btn, logic [2:0] p1, logic [2:0] p2, logic rdy,
                              int cyc, logic valid, logic [2:0] id, logic [2:0] val,
                              logic [5:0] mask, logic multi, logic [2:0] cnt);
    vec_t v;
    v.btn = btn; v.p1 = p1; v.p2 = p2; v.rdy = rdy; v.cyc = cyc;
    v.valid = valid; v.id = id; v.val = val; v.mask = mask; v.multi = multi; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic valid, input logic [2:0] id,
                         input logic [2:0] val, input logic [5:0] mask, input logic multi,
                         input logic [2:0] cnt);
    chk({tag, ".valid"}, 8'(press_valid), 8'(valid));
    chk({tag, ".id"},    8'(press_id),    8'(id));
    chk({tag, ".val"},   8'(press_val),   8'(val));
    chk({tag, ".mask"},  8'(press_mask),  8'(mask));
    chk({tag, ".multi"}, 8'(multi_press), 8'(multi));
    chk({tag, ".count"}, 8'(fifo_count),  8'(cnt));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // single press, short glitch, simultaneous pair, staggered pair
    vecs[0]  = mk(6'b000001, 3'd1, 3'd0, 1'b1,  6, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[1]  = mk(6'b000001, 3'd1, 3'd0, 1'b1,  1, 1'b1, 3'd1, 3'd1, 6'b000001, 1'b0, 3'd1);
    vecs[2]  = mk(6'b000001, 3'd1, 3'd0, 1'b1,  1, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[3]  = mk(6'b000001, 3'd1, 3'd0, 1'b1,  2, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[4]  = mk(6'b000000, 3'd1, 3'd0, 1'b1, 12, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[5]  = mk(6'b000100, 3'd1, 3'd0, 1'b1,  2, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[6]  = mk(6'b000000, 3'd1, 3'd0, 1'b1, 10, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[7]  = mk(6'b000011, 3'd0, 3'd5, 1'b0,  7, 1'b1, 3'd1, 3'd0, 6'b000011, 1'b1, 3'd1);
    vecs[8]  = mk(6'b000011, 3'd0, 3'd5, 1'b1,  1, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[9]  = mk(6'b000000, 3'd0, 3'd5, 1'b1, 10, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[10] = mk(6'b000010, 3'd3, 3'd6, 1'b0,  3, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[11] = mk(6'b000011, 3'd3, 3'd6, 1'b0,  4, 1'b1, 3'd2, 3'd6, 6'b000010, 1'b0, 3'd1);
    vecs[12] = mk(6'b000011, 3'd3, 3'd6, 1'b0,  3, 1'b1, 3'd2, 3'd6, 6'b000010, 1'b0, 3'd2);
    vecs[13] = mk(6'b000011, 3'd3, 3'd6, 1'b1,  1, 1'b1, 3'd1, 3'd3, 6'b000001, 1'b0, 3'd1);
    vecs[14] = mk(6'b000011, 3'd3, 3'd6, 1'b1,  1, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);
    vecs[15] = mk(6'b000000, 3'd3, 3'd6, 1'b1, 10, 1'b0, 3'd0, 3'd0, 6'b000000, 1'b0, 3'd0);

    step(2);
    chk_out("reset", 1'b0, 3'd0, 3'd0, 6'b0, 1'b0, 3'd0);
    chk("reset.overflow", 8'(overflow), 8'd0);
    reset = 1'b0;

    for (int k = 0; k < NumVecs; k++) begin
      player_clk  = vecs[k].btn;
      player1     = vecs[k].p1;
      player2     = vecs[k].p2;
      press_ready = vecs[k].rdy;
      step(vecs[k].cyc);
      chk_out($sformatf("v%0d", k), vecs[k].valid, vecs[k].id, vecs[k].val, vecs[k].mask,
              vecs[k].multi, vecs[k].cnt);
    end
    chk("table.overflow", 8'(overflow), 8'd0);

    // Five staggered presses into a depth-4 queue with the consumer stalled.
    press_ready = 1'b0;
    player1 = 3'd1; player2 = 3'd2; player3 = 3'd3; player4 = 3'd4; player5 = 3'd5;
    for (int p = 0; p < 5; p++) begin
      player_clk[p] = 1'b1;
      if (p < 4) step(2);
    end
    step(6);
    chk("ovf.count4", 8'(fifo_count), 8'd4);
    chk("ovf.before", 8'(overflow), 8'd0);
    step(2);
    chk("ovf.set", 8'(overflow), 8'd1);
    chk_out("ovf.head", 1'b1, 3'd1, 3'd1, 6'b000001, 1'b0, 3'd4);
    press_ready = 1'b1;
    for (int p = 2; p <= 4; p++) begin
      step(1);
      chk_out($sformatf("drain%0d", p), 1'b1, 3'(p), 3'(p), 6'(1 << (p - 1)), 1'b0, 3'(5 - p));
    end
    step(1);
    chk_out("drain.empty", 1'b0, 3'd0, 3'd0, 6'b0, 1'b0, 3'd0);
    chk("ovf.sticky", 8'(overflow), 8'd1);
    press_ready = 1'b0;
    player_clk  = '0;
    step(12);
    chk("ovf.idle", 8'(fifo_count), 8'd0);

    // Reset with two queued events and buttons held through it.
    player6 = 3'd7;
    player_clk[5] = 1'b1;
    step(2);
    player_clk[4] = 1'b1;
    step(8);
    chk_out("rst.pre", 1'b1, 3'd6, 3'd7, 6'b100000, 1'b0, 3'd2);
    reset = 1'b1;
    #1;
    chk_out("rst.now", 1'b0, 3'd0, 3'd0, 6'b0, 1'b0, 3'd0);
    chk("rst.overflow", 8'(overflow), 8'd0);
    step(2);
    reset = 1'b0;
    step(6);
    chk_out("rst.lat", 1'b0, 3'd0, 3'd0, 6'b0, 1'b0, 3'd0);
    step(1);
    chk_out("rst.press", 1'b1, 3'd5, 3'd5, 6'b110000, 1'b1, 3'd1);
    step(10);
    chk("rst.once", 8'(fifo_count), 8'd1);
    chk("rst.ovf", 8'(overflow), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_input_sync.md
PLAYER_INPUT_SYNC -- requirements
Module: player_input_sync

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive clk cycles a synchronized button level must differ from its debounced level before the debounced level flips.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event-queue entries (power of two).
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 player_clk  in  6  raw active-high player buttons, asynchronous to clk; bit i = player i+1.
REQ-006 player1..player6  in  3 each  raw player choice values, asynchronous to clk.
REQ-007 press_ready  in  1  downstream game stage accepts the head event.
REQ-008 press_valid  out  1  event queue non-empty; head event on outputs.
REQ-009 press_id  out  3  player number 1..6 of head event; 000 when empty.
REQ-010 press_val  out  3  choice value of press_id captured at press; 000 when empty.
REQ-011 press_mask  out  6  all players whose press was detected in the same cycle as the head event.
REQ-012 multi_press  out  1  head event has more than one bit set in press_mask.
REQ-013 overflow  out  1  sticky; an event was dropped because the queue was full.
REQ-014 fifo_count  out  3  occupied entries, 0..FIFO_DEPTH.

Function
REQ-015 Each player_clk bit and each player value bit SHALL pass through a 2-flop synchronizer.
REQ-016 Each button SHALL have a debouncer: counter increments while synced level != debounced level, clears when equal; debounced level flips when counter reaches DEBOUNCE_CYCLES, then counter clears.
REQ-017 A press SHALL be a debounced 0->1 transition; releases generate no event.
REQ-018 A raw level held for fewer than DEBOUNCE_CYCLES synced cycles SHALL produce no event and no debounced change.
REQ-019 Every cycle with at least one press SHALL push exactly one entry: press_mask = all presses that cycle, press_id = lowest-numbered pressed player, press_val = that player's synced value in the same cycle, multi = popcount(mask)>1.
REQ-020 Latency: with an empty queue, a raw button rising before clk edge 0 and held stable SHALL give press_valid=1 after edge DEBOUNCE_CYCLES+2 (edge 6 with default).
REQ-021 Queue is show-ahead FIFO; pop occurs on a rising edge where press_valid & press_ready.
REQ-022 press_ready while empty SHALL have no effect.
REQ-023 Push while full without same-cycle pop SHALL drop the new entry and set overflow; queue contents unchanged.
REQ-024 Push while full with same-cycle pop SHALL succeed; fifo_count stays FIFO_DEPTH.
REQ-025 Simultaneous push and pop at any other occupancy SHALL leave fifo_count unchanged.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.

Reset
REQ-027 On reset: synchronizers, debounced levels, counters 0; queue empty; press_valid 0, press_id 000, press_val 000, press_mask 000000, multi_press 0, overflow 0, fifo_count 0.
REQ-028 overflow SHALL clear only on reset.
REQ-029 A button held through reset deassertion SHALL produce exactly one press after the REQ-020 latency.
REQ-030 Reset asserted mid-debounce or with a non-empty queue SHALL discard all pending state immediately.

Structure
REQ-031 Shared package player_input_pkg SHALL hold NUM_PLAYERS=6, PLAYER_ID_W=3, VALUE_W=3, and the event record typedef {id, val, mask, multi}.
REQ-032 One sub-module btn_debounce (synchronizer + debouncer + edge detect, one button) SHALL be instantiated NUM_PLAYERS times; encoder and FIFO stay in player_input_sync.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-033 player1=001, player_clk[0] high 10 cycles, press_ready=1 -> press_valid pulses 1 cycle at edge 6, press_id=001, press_val=001, mask=000001, multi=0.
REQ-034 player_clk[2] high 2 cycles, then low -> no event, fifo_count stays 0.
REQ-035 player_clk[0] and [1] rise same cycle, player1=000 -> one entry, id=001, mask=000011, multi=1.
REQ-036 player_clk[1] rises, player_clk[0] rises 3 cycles later -> two entries in order: id=010, then id=001, both multi=0.
REQ-037 press_ready=0, five separate presses -> fifo_count=4, overflow=1, first four events drain in order; fifth absent.
REQ-038 reset pulsed with two queued entries and a button held -> outputs all zero immediately; one new press event after release latency.
